sample_readback: RTL

SAMPLE_READBACK -- requirements
Module: sample_readback

---
 rtl/sample_readback_if.sv | 46 ++++
 rtl/sample_readback.sv | 124 ++++++++++++
 2 files changed

// File: rtl/sample_readback_if.sv
// Readback block bus: the control strobes and status, the memory read port and
// the decoded-sample stream. The block connects through "master", the environment through "slave".
interface sample_readback_if #(
  parameter int SAMPLE_WIDTH        = 16,
  parameter int SAMPLE_PACKET_WIDTH = 32
);
  localparam int IW = SAMPLE_PACKET_WIDTH - SAMPLE_WIDTH;

  logic                           start;
  logic                           abort;
  logic [31:0]                    begin_num;
  logic [31:0]                    trig_num;
  logic [31:0]                    sample_count;

  logic                           rd_req;
  logic [31:0]                    rd_addr;
  logic                           rd_ack;
  logic                           rd_data_valid;
  logic [SAMPLE_PACKET_WIDTH-1:0] rd_data;

  logic                           out_valid;
  logic                           out_ready;
  logic [SAMPLE_WIDTH-1:0]        out_data;
  logic [IW-1:0]                  out_interval;
  logic [47:0]                    out_timestamp;
  logic                           out_is_trigger;
  logic                           out_last;

  logic                           busy;
  logic                           done;
  logic                           error;

  modport master (
    input  start, abort, begin_num, trig_num, sample_count,
           rd_ack, rd_data_valid, rd_data, out_ready,
    output rd_req, rd_addr, out_valid, out_data, out_interval, out_timestamp,
           out_is_trigger, out_last, busy, done, error
  );

  modport slave (
    output start, abort, begin_num, trig_num, sample_count,
           rd_ack, rd_data_valid, rd_data, out_ready,
    input  rd_req, rd_addr, out_valid, out_data, out_interval, out_timestamp,
           out_is_trigger, out_last, busy, done, error
  );
endinterface

// File: rtl/sample_readback.sv
// Reads a run of sample packets from memory, one read in flight at a time, and
// streams them out decoded with a running timestamp, trigger and last flags.
module sample_readback #(
  parameter int          SAMPLE_WIDTH        = 16,
  parameter int          SAMPLE_PACKET_WIDTH = 32,
  parameter int unsigned MAX_SAMPLE_NUMBER   = 33554431
) (
  input logic               clk,
  input logic               reset,
  sample_readback_if.master bus
);
  localparam logic [31:0] MAX_NUM = 32'(MAX_SAMPLE_NUMBER);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, OUT, DONE} state_t;

  state_t                         state;
  state_t                         state_next;
  logic [31:0]                    cur;
  logic [31:0]                    remaining;
  logic [31:0]                    trig;
  logic [47:0]                    ts;
  logic                           first;
  logic [SAMPLE_PACKET_WIDTH-1:0] pkt;
  logic                           error_q;

  logic load;
  logic bad_start;
  logic capture;
  logic advance;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path infers a latch.
    state_next = state;
    load       = 1'b0;
    bad_start  = 1'b0;
    capture    = 1'b0;
    advance    = 1'b0;
    case (state)
      IDLE: if (bus.start) begin
        if (bus.sample_count == 32'd0) begin
          state_next = DONE;
        end else if (bus.begin_num > MAX_NUM) begin
          bad_start = 1'b1;
        end else begin
          load       = 1'b1;
          state_next = REQ;
        end
      end
      REQ:  if (bus.rd_ack) state_next = WAIT;
      WAIT: if (bus.rd_data_valid) begin
        capture    = 1'b1;
        state_next = OUT;
      end
      OUT:  if (bus.out_ready) begin
        if (remaining == 32'd1) begin
          state_next = DONE;
        end else begin
          advance    = 1'b1;
          state_next = REQ;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // Abort wins over everything, including any datapath update this cycle.
    if (bus.abort) begin
      state_next = IDLE;
      load       = 1'b0;
      bad_start  = 1'b0;
      capture    = 1'b0;
      advance    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur       <= '0;
      remaining <= '0;
      trig      <= '0;
      ts        <= '0;
      first     <= 1'b0;
      pkt       <= '0;
      error_q   <= 1'b0;
    end else begin
      error_q <= bad_start;
      if (load) begin
        cur       <= bus.begin_num;
        remaining <= bus.sample_count;
        trig      <= bus.trig_num;
        ts        <= '0;
        first     <= 1'b1;
      end
      if (capture) begin
        pkt   <= bus.rd_data;
        first <= 1'b0;
        // Timestamp advances by the new packet's own interval plus one.
        ts    <= first ? 48'd0
                       : ts + 48'(bus.rd_data[SAMPLE_PACKET_WIDTH-1:SAMPLE_WIDTH]) + 48'd1;
      end
      if (advance) begin
        remaining <= remaining - 32'd1;
        cur       <= (cur == MAX_NUM) ? 32'd0 : cur + 32'd1;
      end
    end
  end

  assign bus.rd_req         = (state == REQ);
  assign bus.rd_addr        = cur;
  assign bus.out_valid      = (state == OUT);
  assign bus.out_data       = pkt[SAMPLE_WIDTH-1:0];
  assign bus.out_interval   = pkt[SAMPLE_PACKET_WIDTH-1:SAMPLE_WIDTH];
  assign bus.out_timestamp  = ts;
  assign bus.out_is_trigger = (state == OUT) && (cur == trig);
  assign bus.out_last       = (state == OUT) && (remaining == 32'd1);
  assign bus.busy           = (state != IDLE);
  assign bus.done           = (state == DONE);
  assign bus.error          = error_q;
endmodule
